// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Shared fetch-state encodings, queue entry layout and defaults.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_t;

    localparam logic [29:0] c_default_reset_pc = 30'h100000;
    localparam int          c_entry_w          = 62;

    typedef struct packed {
        logic [31:0] inst;
        logic [29:0] pc_plus4;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/inst_fifo.sv
// ============================================================================
// Module   : inst_fifo
// Purpose  : DEPTH-entry synchronous FIFO with flush, count and head output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 62,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [CW-1:0]    o_count,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch front end with req/ack memory port, prefetch
//            queue and branch-redirect flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [29:0] RESET_PC = c_default_reset_pc
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [29:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [29:0] inst_pc_plus4,
    input  logic        inst_ready
);

    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [29:0]        r_fetch_pc;
    logic [29:0]        w_fetch_pc_next;
    logic [29:0]        r_drop_addr;
    logic [c_cnt_w-1:0] w_count;
    logic [c_cnt_w-1:0] w_count_next;
    logic               w_room;
    logic               w_push;
    logic               w_pop;
    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head;

    assign w_pop        = inst_valid & inst_ready & ~redirect;
    assign w_push       = imem_ack & (r_state == FETCH_WAIT) & ~redirect;
    assign w_count_next = w_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    assign w_room       = (w_count_next < c_cnt_w'(DEPTH));

    assign w_push_entry.inst     = imem_data;
    assign w_push_entry.pc_plus4 = r_fetch_pc + 30'd1;

    inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_entry_w)
    ) u_inst_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (redirect),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_entry),
        .o_count (w_count),
        .o_head  (w_head)
    );

    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        if (redirect) begin
            w_fetch_pc_next = redirect_pc;
            // A request still in flight must finish before the new path starts.
            if ((r_state != FETCH_IDLE) && !imem_ack) begin
                w_state_next = FETCH_DROP;
            end else begin
                w_state_next = FETCH_IDLE;
            end
        end else begin
            case (r_state)
                FETCH_IDLE: begin
                    if (w_room) begin
                        w_state_next = FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_ack) begin
                        w_fetch_pc_next = r_fetch_pc + 30'd1;
                        w_state_next    = w_room ? FETCH_WAIT : FETCH_IDLE;
                    end
                end
                FETCH_DROP: begin
                    if (imem_ack) begin
                        w_state_next = FETCH_IDLE;
                    end
                end
                default: w_state_next = FETCH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= FETCH_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_drop_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            if (r_state == FETCH_WAIT) begin
                r_drop_addr <= r_fetch_pc;
            end
        end
    end

    // In DROP the memory still owns the old address even though fetch_pc moved.
    assign imem_req      = (r_state == FETCH_WAIT) || (r_state == FETCH_DROP);
    assign imem_addr     = (r_state == FETCH_DROP) ? r_drop_addr : r_fetch_pc;
    assign inst_valid    = (w_count != '0);
    assign inst          = inst_valid ? w_head.inst : 32'h0;
    assign inst_pc_plus4 = inst_valid ? w_head.pc_plus4 : 30'h0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Scoreboard bench for fetch_unit with directed and random traffic.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam logic [29:0] c_rpc = 30'h100000;

    logic        clk         = 1'b0;
    logic        reset       = 1'b0;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack    = 1'b0;
    logic [31:0] imem_data   = 32'h0;
    logic        redirect    = 1'b0;
    logic [29:0] redirect_pc = 30'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [29:0] inst_pc_plus4;
    logic        inst_ready  = 1'b0;

    int errors = 0;
    int checks = 0;
    int pops   = 0;

    logic [31:0] exp_inst_q [$];
    logic [29:0] exp_pc_q   [$];
    logic [29:0] gen_pc = c_rpc;
    logic [31:0] mon_ei;
    logic [29:0] mon_ep;
    bit          pend = 1'b0;
    logic [29:0] held_addr = 30'h0;

    fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (c_rpc)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc_plus4 (inst_pc_plus4),
        .inst_ready    (inst_ready)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        logic [31:0] x;
        x = {2'b00, a} * 32'h9E3779B1;
        return x ^ 32'h13572468;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Program-order stream: decode must see gen_pc, gen_pc+1, ... from the last restart.
    task automatic refill();
        while (exp_pc_q.size() < 16) begin
            exp_inst_q.push_back(mem_word(gen_pc));
            gen_pc = gen_pc + 30'd1;
            exp_pc_q.push_back(gen_pc);
        end
    endtask

    task automatic flush_to(input logic [29:0] pc);
        exp_inst_q.delete();
        exp_pc_q.delete();
        gen_pc = pc;
        refill();
    endtask

    task automatic step(input bit ack_en, input bit rdy, input bit redir,
                        input logic [29:0] rpc, input bit bad);
        @(posedge clk);
        #1;
        imem_ack    = ack_en & imem_req;
        imem_data   = imem_ack ? (bad ? 32'hDEADBEEF : mem_word(imem_addr)) : 32'h0;
        inst_ready  = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        if (redir) flush_to(rpc);
        else refill();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset      = 1'b0;
        imem_ack   = 1'b0;
        redirect   = 1'b0;
        inst_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        flush_to(c_rpc);
    endtask

    // Monitor: address stability of requests, in-order delivery, zeroed idle head.
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            pend = 1'b0;
        end else begin
            if (imem_req) begin
                if (pend) check("imem_addr_stable", imem_addr, held_addr);
                else begin
                    pend      = 1'b1;
                    held_addr = imem_addr;
                end
                if (imem_ack) pend = 1'b0;
            end
            if (inst_valid && inst_ready && !redirect) begin
                if (exp_pc_q.size() == 0) begin
                    check("scoreboard_empty", 64'd1, 64'd0);
                end else begin
                    mon_ei = exp_inst_q.pop_front();
                    mon_ep = exp_pc_q.pop_front();
                    check("inst", inst, mon_ei);
                    check("inst_pc_plus4", inst_pc_plus4, mon_ep);
                    pops++;
                end
            end
            if (!inst_valid) check("empty_head_zero", {inst, inst_pc_plus4}, 64'd0);
        end
    end

    initial begin
        logic [29:0] old_addr;
        int acks;
        int ackp;
        int rdyp;

        #12;
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, c_rpc);
        check("rst_valid", inst_valid, 0);
        check("rst_inst", {inst, inst_pc_plus4}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        flush_to(c_rpc);

        // Back-to-back fetch with single-cycle acks.
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, 30'h0, 0);
            @(negedge clk);
            check("seq_req", imem_req, 1);
            check("seq_addr", imem_addr, c_rpc + 30'(i));
            if (i > 0) check("seq_pc_plus4", inst_pc_plus4, c_rpc + 30'(i));
        end

        // Fill the queue with decode stalled.
        do_reset();
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0, 30'h0, 0);
            if (imem_ack) acks++;
        end
        @(negedge clk);
        check("full_acks", acks, 4);
        check("full_req", imem_req, 0);
        check("full_valid", inst_valid, 1);
        step(0, 1, 0, 30'h0, 0);
        @(negedge clk);
        check("pop_cycle_req", imem_req, 0);
        step(0, 0, 0, 30'h0, 0);
        @(negedge clk);
        check("after_pop_req", imem_req, 1);
        old_addr = imem_addr;

        // Redirect while a request is outstanding; its late data must vanish.
        step(0, 0, 1, 30'h200, 0);
        @(negedge clk);
        check("redir_req_held", imem_req, 1);
        step(0, 0, 0, 30'h0, 0);
        @(negedge clk);
        check("redir_flushed", inst_valid, 0);
        check("drop_addr_held", imem_addr, old_addr);
        step(0, 0, 0, 30'h0, 0);
        step(1, 1, 0, 30'h0, 1);
        step(0, 1, 0, 30'h0, 0);
        @(negedge clk);
        check("post_drop_idle", imem_req, 0);
        step(0, 1, 0, 30'h0, 0);
        @(negedge clk);
        check("target_req", imem_req, 1);
        check("target_addr", imem_addr, 30'h200);
        step(1, 1, 0, 30'h0, 0);
        step(0, 0, 0, 30'h0, 0);
        @(negedge clk);
        check("target_valid", inst_valid, 1);
        check("target_pc_plus4", inst_pc_plus4, 30'h201);
        check("target_inst", inst, mem_word(30'h200));

        // Redirect coinciding with ack and pop, then address wrap.
        step(1, 1, 1, 30'h3FFFFFFF, 0);
        step(0, 0, 0, 30'h0, 0);
        @(negedge clk);
        check("flush_valid", inst_valid, 0);
        check("flush_inst", inst, 0);
        check("flush_idle", imem_req, 0);
        step(0, 0, 0, 30'h0, 0);
        @(negedge clk);
        check("wrap_req", imem_req, 1);
        check("wrap_addr", imem_addr, 30'h3FFFFFFF);
        step(1, 0, 0, 30'h0, 0);
        step(0, 0, 0, 30'h0, 0);
        @(negedge clk);
        check("wrap_pc_plus4", inst_pc_plus4, 30'h0);
        check("wrap_valid", inst_valid, 1);
        check("wrap_next_addr", imem_addr, 30'h0);

        // Asynchronous reset mid-request with two entries queued.
        step(1, 0, 0, 30'h0, 0);
        step(0, 0, 0, 30'h0, 0);
        @(negedge clk);
        check("pre_rst_valid", inst_valid, 1);
        check("pre_rst_req", imem_req, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_req", imem_req, 0);
        check("async_valid", inst_valid, 0);
        check("async_addr", imem_addr, c_rpc);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_data  = 32'hDEADBEEF;
        inst_ready = 1'b1;
        flush_to(c_rpc);
        step(0, 1, 0, 30'h0, 0);
        @(negedge clk);
        check("post_rst_req", imem_req, 1);
        check("post_rst_addr", imem_addr, c_rpc);
        step(1, 1, 0, 30'h0, 0);
        step(0, 1, 0, 30'h0, 0);
        @(negedge clk);
        check("post_rst_pc_plus4", inst_pc_plus4, c_rpc + 30'd1);

        // Random traffic: varying memory latency, decode stalls and redirects.
        for (int blk = 0; blk < 8; blk++) begin
            ackp = int'($urandom_range(20, 100));
            rdyp = int'($urandom_range(10, 100));
            for (int i = 0; i < 500; i++) begin
                step($urandom_range(0, 99) < ackp,
                     $urandom_range(0, 99) < rdyp,
                     $urandom_range(0, 99) < 3,
                     ($urandom_range(0, 7) == 0) ? (30'h3FFFFFFE + 30'($urandom_range(0, 1)))
                                                 : 30'($urandom),
                     0);
            end
        end
        @(negedge clk);
        check("delivered_some", pops > 300, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
